aes_host_if: RTL and testbench
==============================

# aes_host_if

Parametrised host register interface that sits between the narrow external pins (address, data_in, data_out) and the AES core. It assembles 128/256-bit keys and 128-bit blocks from multi-beat writes and holds the configuration. It generates single-cycle init/next start pulses and captures the core result, which the host then reads back in DOUT_W-bit beats. This is the generalised successor of the fixed 16-in/8-out wrapper: bus widths are parameters, load progress is tracked per beat, and start errors are reported.

## Interface
- DIN_W, 16, write data width; must divide 128.
- DOUT_W, 8, read data width; must divide 128 and be ≥ 8.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- address  in  4  register select, sampled every cycle.
- data_in  in  DIN_W  write data, sampled every cycle while address is a write register.
- data_out  out  DOUT_W  registered read data.
- core_encdec, core_keylen  out  1 each  configuration to the core.
- core_init, core_next  out  1 each  single-cycle start pulses.
- core_key  out  256  assembled key.
- core_block  out  128  assembled block.
- core_ready  in  1  core idle.
- core_result  in  128  core output.
- core_result_valid  in  1  result-valid strobe or level.

## Operation
- Address map:
  - 0x1 CONFIG: write data_in[0]=encdec, data_in[1]=keylen.
  - 0x2 KEY.
  - 0x3 BLOCK.
  - 0x5 STATUS (read).
  - 0x6 START: write data_in[0]=init, data_in[1]=next; read gives config.
  - 0x7 RESULT (read).
  - All other addresses: no write effect; read value is 0.
- CONFIG: the register loads on every cycle that address==0x1.
- KEY: on every cycle at 0x2, key_sr <= {key_sr[255-DIN_W:0], data_in}, so data is MSB-first.
  - Beat counter k_cnt is cleared on the first cycle of entering 0x2, increments per beat, and saturates at 256/DIN_W.
  - Once saturated, further beats keep shifting and the oldest data is lost.
  - key_loaded is set when k_cnt reaches the required count: 128/DIN_W if keylen=0, 256/DIN_W if keylen=1.
  - core_key is key_sr when keylen=1. When keylen=0 it is {key_sr[127:0],128'h0}.
- BLOCK: same scheme as KEY on a 128-bit shift register.
  - Counter b_cnt saturates at 128/DIN_W; block_loaded is set at 128/DIN_W beats.
- START: generates a pulse only on the first cycle of entering 0x6 (edge of address match), never on a held address.
  - core_init = data_in[0] & core_ready; core_next = data_in[1] & core_ready & ~data_in[0]. If both bits are set, init wins.
  - If either bit is set while core_ready=0: no pulse, and the sticky start_err bit is set.
  - Any issued pulse clears result_valid.
- Result capture: on core_result_valid=1, res_reg <= core_result and result_valid <= 1.
- RESULT read: the first cycle at 0x7 clears pointer r_ptr and returns res_reg[127 -: DOUT_W].
  - Each subsequent cycle advances one beat. After 128/DOUT_W beats r_ptr wraps to 0.
- STATUS read value: {0…, start_err, block_loaded, key_loaded, result_valid, core_ready} in bits [4:0].
  - A STATUS read cycle clears start_err on the following edge.
- START read value: {0…, keylen, encdec, next_last, init_last} in bits [3:0], where next_last/init_last are the last written START bits.
- Changing keylen clears key_loaded.

## Timing
- Reset: every register, pulse and counter is 0, and data_out = 0.
- Write-to-register latency: 1 cycle.
- data_out latency: 1 cycle after the address is presented.
- core_init/core_next: exactly 1 cycle high, on the edge after START is entered.
- Simultaneous result capture and start pulse in the same cycle: the start pulse wins and result_valid ends at 0.
- Asynchronous reset mid-load or mid-read: counters, loaded flags and pointers return to 0 immediately.

## Structure
- Package aes_host_pkg holds:
  - the address localparams (ADDR_CONFIG…ADDR_RESULT);
  - the bit indices (CONFIG_ENCDEC_BIT, CONFIG_KEYLEN_BIT, START_INIT_BIT, START_NEXT_BIT, the STATUS_* bits);
  - the KEY128/256 beat-count functions.
- One sub-module, aes_beat_loader (parameters W, DEPTH_BITS, MAX_BEATS), is instantiated twice (key, block): shift register, saturating counter and entry-edge clear.

## Test plan
- Reset, then address=0, data_in=16'habcd for 5 cycles -> data_out stays 8'h00, no core_init/core_next.
- CONFIG write 2'b11, then move to START with data_in=0 -> next cycle data_out=8'b0000_1100, no pulse.
- keylen=1, 16 KEY beats of 16'h0001..16'h0010 -> core_key = 256'h0001_0002…0010 and key_loaded=1 after beat 16. Switch to keylen=0 -> key_loaded=0.
- START with data_in=2'b01 and core_ready=1 -> core_init high exactly 1 cycle. Repeat with core_ready=0 -> no pulse, STATUS bit4=1, then clears after one STATUS read.
- core_result_valid with core_result=128'h00112233…ff, then RESULT held 17 cycles -> data_out sequence 00,11,…,ff,00 (wrap).
- Assert rst_n=0 after 3 BLOCK beats -> b_cnt=0, block_loaded=0, data_out=0 immediately.

Source files
------------

// File: rtl/aes_host_pkg.sv
// aes_host_pkg: address map, register bit positions and beat-count helpers for aes_host_if
package aes_host_pkg;
  localparam logic [3:0] ADDR_CONFIG = 4'h1;
  localparam logic [3:0] ADDR_KEY    = 4'h2;
  localparam logic [3:0] ADDR_BLOCK  = 4'h3;
  localparam logic [3:0] ADDR_STATUS = 4'h5;
  localparam logic [3:0] ADDR_START  = 4'h6;
  localparam logic [3:0] ADDR_RESULT = 4'h7;
  localparam int CONFIG_ENCDEC_BIT = 0;
  localparam int CONFIG_KEYLEN_BIT = 1;
  localparam int START_INIT_BIT    = 0;
  localparam int START_NEXT_BIT    = 1;
  localparam int STATUS_READY_BIT  = 0;
  localparam int STATUS_VALID_BIT  = 1;
  localparam int STATUS_KEY_BIT    = 2;
  localparam int STATUS_BLOCK_BIT  = 3;
  localparam int STATUS_ERR_BIT    = 4;
  function automatic int key128_beats(input int w);
    return 128 / w;
  endfunction
  function automatic int key256_beats(input int w);
    return 256 / w;
  endfunction
endpackage

// File: rtl/aes_beat_loader.sv
// aes_beat_loader: MSB-first shift register fed one W-bit beat per enabled cycle, with saturating beat count
module aes_beat_loader #(
  parameter int W          = 16,
  parameter int DEPTH_BITS = 5,
  parameter int MAX_BEATS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    first,
  input  logic [W-1:0]            data,
  output logic [W*MAX_BEATS-1:0]  sr,
  output logic [DEPTH_BITS-1:0]   cnt_nxt
);
  localparam int N = W * MAX_BEATS;
  localparam logic [DEPTH_BITS-1:0] MAX = DEPTH_BITS'(MAX_BEATS);
  logic [DEPTH_BITS-1:0] cnt;
  // the entry beat itself counts, so a fresh run starts at 1
  always_comb cnt_nxt = first ? DEPTH_BITS'(1) : (cnt == MAX ? cnt : cnt + 1'b1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      sr  <= N'({sr, data});
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/aes_host_if.sv
// aes_host_if: narrow host register interface that loads key/block beats, starts the AES core and reads back the result
module aes_host_if
  import aes_host_pkg::*;
#(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        address,
  input  logic [DIN_W-1:0]  data_in,
  output logic [DOUT_W-1:0] data_out,
  output logic              core_encdec,
  output logic              core_keylen,
  output logic              core_init,
  output logic              core_next,
  output logic [255:0]      core_key,
  output logic [127:0]      core_block,
  input  logic              core_ready,
  input  logic [127:0]      core_result,
  input  logic              core_result_valid
);
  localparam int K128 = key128_beats(DIN_W);
  localparam int K256 = key256_beats(DIN_W);
  localparam int KD   = $clog2(K256 + 1);
  localparam int BD   = $clog2(K128 + 1);
  localparam int NR   = 128 / DOUT_W;
  localparam int RB   = NR > 1 ? $clog2(NR) : 1;
  logic [3:0]        addr_q;
  logic              key_loaded, block_loaded, init_last, next_last, start_err, result_valid;
  logic [127:0]      res_reg;
  logic [RB-1:0]     r_ptr, r_sel;
  logic [255:0]      key_sr;
  logic [KD-1:0]     k_nxt;
  logic [BD-1:0]     b_nxt;
  logic              key_en, block_en, start_edge, init_go, next_go;
  logic [DOUT_W-1:0] rd;
  always_comb begin
    key_en     = address == ADDR_KEY;
    block_en   = address == ADDR_BLOCK;
    start_edge = address == ADDR_START && addr_q != ADDR_START;
    init_go    = start_edge & data_in[START_INIT_BIT] & core_ready;
    next_go    = start_edge & data_in[START_NEXT_BIT] & core_ready & ~data_in[START_INIT_BIT];
    r_sel      = addr_q != ADDR_RESULT ? '0 : r_ptr;
    rd = address == ADDR_STATUS ? DOUT_W'({start_err, block_loaded, key_loaded, result_valid, core_ready}) :
         address == ADDR_START  ? DOUT_W'({core_keylen, core_encdec, next_last, init_last}) :
         address == ADDR_RESULT ? res_reg[127 - int'(r_sel) * DOUT_W -: DOUT_W] : '0;
    core_key = core_keylen ? key_sr : {key_sr[127:0], 128'h0};
  end
  aes_beat_loader #(.W(DIN_W), .DEPTH_BITS(KD), .MAX_BEATS(K256)) u_key (
    .clk, .rst_n, .en(key_en), .first(key_en && addr_q != ADDR_KEY),
    .data(data_in), .sr(key_sr), .cnt_nxt(k_nxt)
  );
  aes_beat_loader #(.W(DIN_W), .DEPTH_BITS(BD), .MAX_BEATS(K128)) u_block (
    .clk, .rst_n, .en(block_en), .first(block_en && addr_q != ADDR_BLOCK),
    .data(data_in), .sr(core_block), .cnt_nxt(b_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q       <= '0;
      data_out     <= '0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_encdec  <= 1'b0;
      core_keylen  <= 1'b0;
      key_loaded   <= 1'b0;
      block_loaded <= 1'b0;
      init_last    <= 1'b0;
      next_last    <= 1'b0;
      start_err    <= 1'b0;
      result_valid <= 1'b0;
      res_reg      <= '0;
      r_ptr        <= '0;
    end else begin
      addr_q    <= address;
      data_out  <= rd;
      core_init <= init_go;
      core_next <= next_go;
      if (address == ADDR_CONFIG) begin
        core_encdec <= data_in[CONFIG_ENCDEC_BIT];
        core_keylen <= data_in[CONFIG_KEYLEN_BIT];
      end
      if (address == ADDR_CONFIG && data_in[CONFIG_KEYLEN_BIT] != core_keylen) key_loaded <= 1'b0;
      else if (key_en && int'(k_nxt) == (core_keylen ? K256 : K128)) key_loaded <= 1'b1;
      if (block_en && int'(b_nxt) == K128) block_loaded <= 1'b1;
      if (address == ADDR_START) begin
        init_last <= data_in[START_INIT_BIT];
        next_last <= data_in[START_NEXT_BIT];
      end
      if (start_edge && (data_in[START_INIT_BIT] || data_in[START_NEXT_BIT]) && !core_ready) start_err <= 1'b1;
      else if (address == ADDR_STATUS) start_err <= 1'b0;
      if (core_result_valid) res_reg <= core_result;
      // a start pulse invalidates the old result even if a new one arrives in the same cycle
      if (init_go || next_go) result_valid <= 1'b0;
      else if (core_result_valid) result_valid <= 1'b1;
      if (address == ADDR_RESULT) r_ptr <= r_sel == RB'(NR - 1) ? '0 : r_sel + 1'b1;
    end
endmodule

// File: tb/tb_aes_host_if.sv
// tb_aes_host_if: randomized scoreboard bench for aes_host_if against a queue-based behavioural model
module tb_aes_host_if;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [3:0]   address = '0;
  logic [15:0]  data_in = '0;
  logic [7:0]   data_out;
  logic         core_encdec, core_keylen, core_init, core_next;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready = 1'b1, core_result_valid = 1'b0;
  logic [127:0] core_result = '0;

  always #5 clk = ~clk;

  aes_host_if #(.DIN_W(16), .DOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in), .data_out(data_out),
    .core_encdec(core_encdec), .core_keylen(core_keylen), .core_init(core_init), .core_next(core_next),
    .core_key(core_key), .core_block(core_block), .core_ready(core_ready),
    .core_result(core_result), .core_result_valid(core_result_valid)
  );

  typedef struct {
    logic [7:0]   dout;
    logic         init, nxt, enc, kl;
    logic [255:0] key;
    logic [127:0] blk;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state: key/block kept as queues of the most recent beats
  logic         m_enc, m_kl, m_kld, m_bld, m_il, m_nl, m_err, m_rv;
  logic [127:0] m_res;
  logic [3:0]   m_prev;
  int           m_rptr, kcnt, bcnt;
  logic [15:0]  kq[$], bq[$];

  task automatic model_reset();
    {m_enc, m_kl, m_kld, m_bld, m_il, m_nl, m_err, m_rv} = '0;
    m_res = '0; m_prev = '0; m_rptr = 0; kcnt = 0; bcnt = 0;
    kq = {}; bq = {};
    repeat (16) kq.push_back(16'h0);
    repeat (8) bq.push_back(16'h0);
  endtask

  function automatic logic [255:0] key_val();
    logic [255:0] v = '0;
    foreach (kq[i]) v = v | (256'(kq[i]) << (16 * (15 - i)));
    return v;
  endfunction

  function automatic logic [127:0] blk_val();
    logic [127:0] v = '0;
    foreach (bq[i]) v = v | (128'(bq[i]) << (16 * (7 - i)));
    return v;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [15:0] d, input logic rdy = 1'b1,
                       input logic rv = 1'b0, input logic [127:0] res = '0);
    exp_t e;
    logic edge6;
    int idx;
    logic [255:0] kv;
    @(negedge clk);
    address = a; data_in = d; core_ready = rdy; core_result_valid = rv; core_result = res;
    idx = m_prev != 4'd7 ? 0 : m_rptr;
    case (a)
      4'd5:    e.dout = {3'b000, m_err, m_bld, m_kld, m_rv, rdy};
      4'd6:    e.dout = {4'b0000, m_kl, m_enc, m_nl, m_il};
      4'd7:    e.dout = 8'(m_res >> (120 - 8 * idx));
      default: e.dout = 8'h00;
    endcase
    edge6  = a == 4'd6 && m_prev != 4'd6;
    e.init = edge6 && d[0] && rdy;
    e.nxt  = edge6 && d[1] && rdy && !d[0];
    if (a == 4'd1) begin
      if (d[1] != m_kl) m_kld = 1'b0;
      m_enc = d[0]; m_kl = d[1];
    end
    if (a == 4'd2) begin
      if (m_prev != 4'd2) kcnt = 0;
      kq.push_back(d); void'(kq.pop_front());
      if (kcnt < 16) kcnt++;
      if (kcnt == (m_kl ? 16 : 8)) m_kld = 1'b1;
    end
    if (a == 4'd3) begin
      if (m_prev != 4'd3) bcnt = 0;
      bq.push_back(d); void'(bq.pop_front());
      if (bcnt < 8) bcnt++;
      if (bcnt == 8) m_bld = 1'b1;
    end
    if (a == 4'd5) m_err = 1'b0;
    if (a == 4'd6) begin
      m_il = d[0]; m_nl = d[1];
      if (edge6 && (d[0] || d[1]) && !rdy) m_err = 1'b1;
    end
    if (a == 4'd7) m_rptr = (idx + 1) % 16;
    if (rv) begin m_res = res; m_rv = 1'b1; end
    if (e.init || e.nxt) m_rv = 1'b0;
    m_prev = a;
    e.enc = m_enc; e.kl = m_kl;
    kv = key_val();
    e.key = m_kl ? kv : {kv[127:0], 128'h0};
    e.blk = blk_val();
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_out", data_out, e.dout);
        chk("core_init", core_init, e.init);
        chk("core_next", core_next, e.nxt);
        chk("core_encdec", core_encdec, e.enc);
        chk("core_keylen", core_keylen, e.kl);
        chk("core_key", core_key, e.key);
        chk("core_block", core_block, e.blk);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ra = '0;
    model_reset();
    #12;
    chk("reset data_out", data_out, 0);
    chk("reset core_init", core_init, 0);
    chk("reset core_next", core_next, 0);
    chk("reset core_key", core_key, 0);
    chk("reset core_block", core_block, 0);
    chk("reset core_encdec", core_encdec, 0);
    chk("reset core_keylen", core_keylen, 0);
    rst_n = 1'b1;
    repeat (5) drive(4'd0, 16'habcd);
    drive(4'd1, 16'h0003);
    drive(4'd6, 16'h0000);
    drive(4'd6, 16'h0000);
    for (int i = 1; i <= 16; i++) drive(4'd2, 16'(i));
    drive(4'd5, 16'h0);
    drive(4'd1, 16'h0001);
    drive(4'd5, 16'h0);
    drive(4'd6, 16'h0001, 1'b1);
    drive(4'd0, 16'h0);
    drive(4'd6, 16'h0001, 1'b0);
    drive(4'd5, 16'h0);
    drive(4'd5, 16'h0);
    drive(4'd0, 16'h0, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff);
    repeat (17) drive(4'd7, 16'h0);
    drive(4'd6, 16'h0003, 1'b1, 1'b1, 128'hdeadbeef);
    drive(4'd5, 16'h0);
    drive(4'd0, 16'h0);
    drive(4'd6, 16'h0002, 1'b1);
    drive(4'd5, 16'h0);
    repeat (1500) begin
      if ($urandom_range(0, 2) == 0)
        ra = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 7));
      drive(ra, 16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            {$urandom, $urandom, $urandom, $urandom});
    end
    drive(4'd0, 16'h0);
    repeat (3) drive(4'd3, 16'($urandom));
    drive(4'd5, 16'h0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset data_out", data_out, 0);
    chk("async reset core_block", core_block, 0);
    chk("async reset core_key", core_key, 0);
    chk("async reset core_init", core_init, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    repeat (3) drive(4'd3, 16'($urandom));
    drive(4'd5, 16'h0);
    drive(4'd0, 16'h0);
    @(posedge clk);
    #2;
    chk("scoreboard drained", 256'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
